// File: rtl/ws2812_rx_if.sv
// Decoded-pixel bus of the WS2812 receiver: serial line in, pixel/frame strobes out.
interface ws2812_rx_if;
  logic        ledIn;
  logic [23:0] pixel;
  logic        pixelValid;
  logic [7:0]  pixelIndex;
  logic        frameDone;
  logic [7:0]  frameLen;
  logic [2:0]  frameErr;

  // The decoder drives the pixel/frame outputs and reads the line.
  modport master (
    input  ledIn,
    output pixel, pixelValid, pixelIndex, frameDone, frameLen, frameErr
  );

  // The consumer drives the line and reads the decoded results.
  modport slave (
    output ledIn,
    input  pixel, pixelValid, pixelIndex, frameDone, frameLen, frameErr
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 line decoder. Measures high-pulse widths on the synchronized data
// line, turns them into bits, assembles 24-bit GRB pixels MSB first and
// reports the end of each frame when the latch gap is seen.
module ws2812_rx #(
  parameter int NUM_LEDS     = 170,
  parameter int MIN_HIGH     = 3,
  parameter int BIT_THRESH   = 12,
  parameter int MAX_HIGH     = 40,
  parameter int RESET_CYCLES = 1024
) (
  input  logic          ledClk,
  input  logic          reset,
  ws2812_rx_if.master   rx
);

  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH + 2);

  localparam logic [LOW_W-1:0]  GAP_M1_C   = LOW_W'(RESET_CYCLES - 1);
  localparam logic [HIGH_W-1:0] MIN_HIGH_C = HIGH_W'(MIN_HIGH);
  localparam logic [HIGH_W-1:0] THRESH_C   = HIGH_W'(BIT_THRESH);
  localparam logic [HIGH_W-1:0] MAX_HIGH_C = HIGH_W'(MAX_HIGH);
  localparam logic [7:0]        NUM_LEDS_C = 8'(NUM_LEDS);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  // Saturating increments: the width counters must never wrap, otherwise a
  // very long low or high could alias to a short one.
  function automatic logic [LOW_W-1:0] sat_inc_low(input logic [LOW_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [HIGH_W-1:0] sat_inc_high(input logic [HIGH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              sync1_q, sync2_q;
  logic              line;

  state_t            state_q, state_d;
  logic [LOW_W-1:0]  lowCnt_q, lowCnt_d;
  logic [HIGH_W-1:0] highCnt_q, highCnt_d;
  logic [4:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        pixCnt_q, pixCnt_d;
  logic [22:0]       shift_q, shift_d;
  logic              errPulse_q, errPulse_d;   // glitch or over-long high seen
  logic              errOvf_q, errOvf_d;       // more pixels than NUM_LEDS seen

  logic [23:0]       pixel_q, pixel_d;
  logic              pixelValid_q, pixelValid_d;
  logic [7:0]        pixelIndex_q, pixelIndex_d;
  logic              frameDone_q, frameDone_d;
  logic [7:0]        frameLen_q, frameLen_d;
  logic [2:0]        frameErr_q, frameErr_d;

  logic              frameActive;
  logic              gap;
  logic              bitDone;
  logic              bitVal;
  logic [23:0]       fullPixel;

  // Two-flop synchronizer for the asynchronous data line.
  always_ff @(posedge ledClk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= rx.ledIn;
      sync2_q <= sync1_q;
    end
  end

  assign line        = sync2_q;
  assign frameActive = (pixCnt_q != 8'd0) || (bitCnt_q != 5'd0) || errPulse_q || errOvf_q;
  assign fullPixel   = {shift_q, bitVal};

  // Decoder state, counters and registered outputs.
  always_ff @(posedge ledClk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      lowCnt_q     <= '0;
      highCnt_q    <= '0;
      bitCnt_q     <= '0;
      pixCnt_q     <= '0;
      shift_q      <= '0;
      errPulse_q   <= 1'b0;
      errOvf_q     <= 1'b0;
      pixel_q      <= '0;
      pixelValid_q <= 1'b0;
      pixelIndex_q <= '0;
      frameDone_q  <= 1'b0;
      frameLen_q   <= '0;
      frameErr_q   <= '0;
    end else begin
      state_q      <= state_d;
      lowCnt_q     <= lowCnt_d;
      highCnt_q    <= highCnt_d;
      bitCnt_q     <= bitCnt_d;
      pixCnt_q     <= pixCnt_d;
      shift_q      <= shift_d;
      errPulse_q   <= errPulse_d;
      errOvf_q     <= errOvf_d;
      pixel_q      <= pixel_d;
      pixelValid_q <= pixelValid_d;
      pixelIndex_q <= pixelIndex_d;
      frameDone_q  <= frameDone_d;
      frameLen_q   <= frameLen_d;
      frameErr_q   <= frameErr_d;
    end
  end

  // Next-state logic: pulse measurement, bit/pixel assembly and gap handling.
  always_comb begin
    state_d      = state_q;
    lowCnt_d     = lowCnt_q;
    highCnt_d    = highCnt_q;
    bitCnt_d     = bitCnt_q;
    pixCnt_d     = pixCnt_q;
    shift_d      = shift_q;
    errPulse_d   = errPulse_q;
    errOvf_d     = errOvf_q;
    pixel_d      = pixel_q;
    pixelValid_d = 1'b0;
    pixelIndex_d = pixelIndex_q;
    frameDone_d  = 1'b0;
    frameLen_d   = frameLen_q;
    frameErr_d   = frameErr_q;
    gap          = 1'b0;
    bitDone      = 1'b0;
    bitVal       = 1'b0;

    case (state_q)
      // Wait for a full latch gap so decoding never starts mid-frame.
      SYNC: begin
        if (line) begin
          lowCnt_d = '0;
        end else begin
          lowCnt_d = sat_inc_low(lowCnt_q);
          if (lowCnt_q == GAP_M1_C) begin
            state_d = LOW;
            gap     = frameActive;
          end
        end
      end

      LOW: begin
        if (line) begin
          state_d   = HIGH;
          highCnt_d = HIGH_W'(1);
          lowCnt_d  = '0;
        end else begin
          lowCnt_d = sat_inc_low(lowCnt_q);
          // Fires only on the exact crossing, so a long low gives one frameDone.
          if ((lowCnt_q == GAP_M1_C) && frameActive) begin
            gap = 1'b1;
          end
        end
      end

      HIGH: begin
        if (highCnt_q > MAX_HIGH_C) begin
          // Over-long high: the framing is lost, resynchronize on the next gap.
          errPulse_d = 1'b1;
          bitCnt_d   = '0;
          lowCnt_d   = '0;
          state_d    = SYNC;
        end else if (line) begin
          highCnt_d = sat_inc_high(highCnt_q);
        end else if (highCnt_q < MIN_HIGH_C) begin
          errPulse_d = 1'b1;
          state_d    = LOW;
        end else begin
          bitDone = 1'b1;
          bitVal  = (highCnt_q >= THRESH_C);
          state_d = LOW;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase

    if (bitDone) begin
      shift_d = {shift_q[21:0], bitVal};
      if (bitCnt_q == 5'd23) begin
        bitCnt_d = '0;
        if (pixCnt_q < NUM_LEDS_C) begin
          pixel_d      = fullPixel;
          pixelIndex_d = pixCnt_q;
          pixelValid_d = 1'b1;
          pixCnt_d     = pixCnt_q + 8'd1;
        end else begin
          errOvf_d = 1'b1;
        end
      end else begin
        bitCnt_d = bitCnt_q + 5'd1;
      end
    end

    // Gap only happens with the line low, so it never meets a pixel strobe.
    if (gap) begin
      frameDone_d = 1'b1;
      frameLen_d  = pixCnt_q;
      frameErr_d  = {errPulse_q, errOvf_q, bitCnt_q != 5'd0};
      pixCnt_d    = '0;
      bitCnt_d    = '0;
      errPulse_d  = 1'b0;
      errOvf_d    = 1'b0;
    end
  end

  assign rx.pixel      = pixel_q;
  assign rx.pixelValid = pixelValid_q;
  assign rx.pixelIndex = pixelIndex_q;
  assign rx.frameDone  = frameDone_q;
  assign rx.frameLen   = frameLen_q;
  assign rx.frameErr   = frameErr_q;

endmodule
